// File: rtl/tournament_scheduler.sv
// Tournament scheduler: sequences ROUNDS minigame rounds (select, interval, start,
// run with blanking/timeout, score) and accumulates the tournament total.
module tournament_scheduler #(
  parameter int ROUNDS          = 3,
  parameter int INTERVAL_CYCLES = 2000,
  parameter int TIMEOUT_CYCLES  = 60000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       aleatorio,
  input  logic       pronto,
  input  logic [2:0] pontuacao,
  output logic [1:0] minigame,
  output logic       jogar,
  output logic [2:0] estado,
  output logic [1:0] rodada,
  output logic [4:0] total,
  output logic       timeout,
  output logic       fim
);

  localparam logic [2:0] IDLE     = 3'b000;
  localparam logic [2:0] SELECT   = 3'b001;
  localparam logic [2:0] INTERVAL = 3'b010;
  localparam logic [2:0] START    = 3'b011;
  localparam logic [2:0] RUN      = 3'b100;
  localparam logic [2:0] SCORE    = 3'b101;
  localparam logic [2:0] DONE     = 3'b110;

  localparam int CMAX = (TIMEOUT_CYCLES > INTERVAL_CYCLES) ? TIMEOUT_CYCLES : INTERVAL_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] INT_LAST = CW'(INTERVAL_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK    = CW'(2);

  logic [2:0]    state, state_n;
  logic [CW-1:0] cnt;
  logic [3:0]    lfsr;
  logic [2:0]    score;
  logic          mode;
  logic          accept, expire, last_round;
  logic [1:0]    cand, pick;

  // Counter is the number of cycles already spent in the current RUN state,
  // so cnt<2 covers the two blanking cycles after START.
  assign accept     = (state == RUN) && (cnt >= BLANK) && pronto;
  assign expire     = (state == RUN) && (cnt == TO_LAST);
  assign last_round = (rodada == 2'(ROUNDS - 1));

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (iniciar) state_n = SELECT;
      SELECT:   state_n = INTERVAL;
      INTERVAL: if (cnt == INT_LAST) state_n = START;
      START:    state_n = RUN;
      RUN:      if (accept || expire) state_n = SCORE;
      SCORE:    state_n = last_round ? DONE : SELECT;
      DONE:     if (iniciar) state_n = SELECT;
      default:  state_n = IDLE;
    endcase
  end

  // Random pick avoids repeating the previous round's game within a tournament.
  always_comb begin
    cand = (lfsr[1:0] == 2'd3) ? 2'd0 : lfsr[1:0];
    pick = cand;
    if (rodada != 2'd0 && cand == minigame)
      pick = (minigame == 2'd2) ? 2'd0 : minigame + 2'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      lfsr     <= 4'b1001;
      minigame <= 2'd0;
      rodada   <= 2'd0;
      total    <= 5'd0;
      timeout  <= 1'b0;
      score    <= 3'd0;
      mode     <= 1'b0;
    end else begin
      state <= state_n;
      lfsr  <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
      cnt   <= (state_n == state && (state == INTERVAL || state == RUN)) ? cnt + CW'(1) : '0;
      case (state)
        IDLE, DONE: begin
          if (iniciar) begin
            total   <= 5'd0;
            timeout <= 1'b0;
            rodada  <= 2'd0;
            mode    <= aleatorio;
          end
        end
        SELECT: minigame <= mode ? pick : rodada;
        RUN: begin
          if (accept || expire) begin
            score <= accept ? pontuacao : 3'd0;
            if (!accept) timeout <= 1'b1;
          end
        end
        SCORE: begin
          total <= total + {2'b00, score};
          if (!last_round) rodada <= rodada + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign estado = state;
  assign jogar  = (state == START);
  assign fim    = (state == DONE);

endmodule

// File: tb/tb_tournament_scheduler.sv
// Directed bench for tournament_scheduler: table of whole tournaments plus
// hand sequences for async reset, reset mid-RUN and random-order reproducibility.
module tb_tournament_scheduler;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic       aleatorio = 1'b0;
  logic       pronto = 1'b0;
  logic [2:0] pontuacao = 3'd0;
  logic [1:0] minigame;
  logic       jogar;
  logic [2:0] estado;
  logic [1:0] rodada;
  logic [4:0] total;
  logic       timeout;
  logic       fim;

  tournament_scheduler #(
    .ROUNDS(3), .INTERVAL_CYCLES(4), .TIMEOUT_CYCLES(10)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .aleatorio(aleatorio),
    .pronto(pronto), .pontuacao(pontuacao), .minigame(minigame), .jogar(jogar),
    .estado(estado), .rodada(rodada), .total(total), .timeout(timeout), .fim(fim)
  );

  always #5 clock = ~clock;

  // One tournament: per-round score, RUN cycle at which pronto rises (0 = never),
  // stale = pronto held high throughout, noise = iniciar toggled mid-round,
  // abort = stop in INTERVAL of the last round.
  typedef struct packed {
    logic            mode;
    logic [2:0][2:0] pts;
    logic [2:0][4:0] pr;
    logic            stale;
    logic            noise;
    logic            abort;
    logic [4:0]      exp_total;
    logic            exp_to;
  } vec_t;

  int n_chk = 0;
  int n_err = 0;
  int n_jogar = 0;

  always @(negedge clock) if (jogar) n_jogar <= n_jogar + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic vec_t mk(input logic m, input int p0, p1, p2, r0, r1, r2,
                              input logic st, nz, ab, input int tot, input logic to);
    vec_t v;
    v.mode = m;
    v.pts[0] = 3'(p0); v.pts[1] = 3'(p1); v.pts[2] = 3'(p2);
    v.pr[0]  = 5'(r0); v.pr[1]  = 5'(r1); v.pr[2]  = 5'(r2);
    v.stale = st; v.noise = nz; v.abort = ab;
    v.exp_total = 5'(tot); v.exp_to = to;
    return v;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_estado"}, estado, 0);
    chk({tag, "_minigame"}, minigame, 0);
    chk({tag, "_jogar"}, jogar, 0);
    chk({tag, "_rodada"}, rodada, 0);
    chk({tag, "_total"}, total, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_fim"}, fim, 0);
  endtask

  // Assert reset between edges, check outputs before the next edge, then release
  // and idle a fixed number of cycles so later LFSR-driven runs line up.
  task automatic do_reset();
    int base;
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    @(posedge clock);
    #4;
    reset = 1'b0;
    base = n_jogar;
    for (int i = 0; i < 20; i++) step();
    chk("rst_no_jogar", n_jogar - base, 0);
    chk("rst_idle", estado, 0);
  endtask

  task automatic tourney(input vec_t v, output logic [2:0][1:0] mg);
    int base_j, k, rc, pe, ers, run_tot;
    logic acc;
    mg = '0;
    base_j = n_jogar;
    run_tot = 0;
    aleatorio = v.mode;
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    aleatorio = ~v.mode;
    chk("enter_select", estado, 1);
    chk("clr_total", total, 0);
    chk("clr_rodada", rodada, 0);
    chk("clr_timeout", timeout, 0);
    for (int r = 0; r < 3; r++) begin
      pronto = v.stale;
      pontuacao = v.pts[r];
      step();
      chk("interval", estado, 2);
      if (!v.mode) chk("mg_seq", minigame, r);
      else begin
        chk("mg_range", int'(minigame <= 2'd2), 1);
        if (r > 0) chk("mg_norepeat", int'(minigame != mg[r-1]), 1);
      end
      mg[r] = minigame;
      if (v.abort && r == 2) begin
        step();
        return;
      end
      iniciar = v.noise;
      k = 1;
      while (!jogar && k < 20) begin
        step();
        k++;
      end
      chk("jogar_latency", k, 5);
      chk("start_state", estado, 3);
      step();
      chk("run_state", estado, 4);
      chk("jogar_one_cycle", jogar, 0);
      rc = 1;
      forever begin
        pronto = v.stale || (v.pr[r] != 0 && rc >= int'(v.pr[r]));
        step();
        if (estado == 3'd5 || rc >= 20) break;
        rc++;
      end
      iniciar = 1'b0;
      pe = v.stale ? 1 : int'(v.pr[r]);
      ers = (pe < 3) ? 3 : pe;
      acc = (pe != 0) && (ers <= 10);
      chk("run_len", rc, acc ? ers : 10);
      if (acc) run_tot += int'(v.pts[r]);
      pronto = 1'b0;
      step();
      chk("total_acc", total, run_tot);
      if (r < 2) begin
        chk("next_select", estado, 1);
        chk("rodada_inc", rodada, r + 1);
      end else begin
        chk("done_state", estado, 6);
        chk("rodada_hold", rodada, 2);
      end
    end
    chk("fim", fim, 1);
    chk("final_total", total, v.exp_total);
    chk("final_timeout", timeout, v.exp_to);
    chk("jogar_count", n_jogar - base_j, 3);
    step();
    step();
    chk("done_hold", estado, 6);
    chk("total_hold", total, v.exp_total);
    chk("mg_hold", minigame, mg[2]);
  endtask

  vec_t vecs[6];
  vec_t v_rand, v_abort;
  logic [2:0][1:0] mg, mg_a, mg_b;

  initial begin
    vecs[0] = mk(0, 5, 3, 7,  3,  3, 3, 0, 0, 0, 15, 0);  // basic sequential
    vecs[1] = mk(0, 4, 7, 4,  3,  0, 5, 0, 1, 0,  8, 1);  // round 1 forfeited, iniciar noise
    vecs[2] = mk(0, 6, 2, 1, 10,  4, 3, 0, 0, 0,  9, 0);  // pronto on expiry cycle wins
    vecs[3] = mk(0, 1, 2, 4,  1,  1, 1, 1, 0, 0,  7, 0);  // stale pronto, blanking
    vecs[4] = mk(0, 7, 7, 7, 11,  3, 2, 0, 0, 0, 14, 1);  // pronto one cycle too late
    vecs[5] = mk(0, 7, 7, 7,  3,  3, 3, 0, 0, 0, 21, 0);  // maximum total
    v_rand  = mk(1, 2, 2, 2,  4,  4, 4, 0, 0, 0,  6, 0);
    v_abort = mk(0, 1, 1, 1,  3,  3, 3, 0, 0, 1,  0, 0);

    @(posedge clock);
    #1;
    chk_reset_vals("init_rst");
    #3;
    reset = 1'b0;
    step();
    step();
    chk("idle_after_rst", estado, 0);

    for (int i = 0; i < 6; i++) tourney(vecs[i], mg);

    // Reset during INTERVAL of the last round, then a clean restart.
    tourney(v_abort, mg);
    chk("abort_rodada", rodada, 2);
    do_reset();
    tourney(vecs[0], mg);

    // Reset mid-RUN discards the pending score.
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    for (int k = 0; k < 20 && !jogar; k++) step();
    chk("midrun_start", estado, 3);
    step();
    pronto = 1'b1;
    pontuacao = 3'd7;
    step();
    step();
    do_reset();
    pronto = 1'b0;
    chk("midrun_total", total, 0);

    // Random order is reproducible from reset.
    tourney(v_rand, mg_a);
    do_reset();
    tourney(v_rand, mg_b);
    chk("rand_repro", int'(mg_b), int'(mg_a));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
